// File: rtl/ser_loader.sv
// Polls a byte-oriented serial receiver, assembles SYNC/ADDR/DHI/DLO/CHK frames and
// presents each checksum-valid frame as a register-write command with a valid/ready handshake.
module ser_loader #(
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ser_en,
  output logic        ser_wr,
  output logic        ser_addr,
  input  logic [7:0]  ser_rdata,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {StPoll, StRead, StIssue} state_e;

  state_e      state_q;
  logic [2:0]  idx_q;
  logic [15:0] tmo_q;
  logic [7:0]  addr_q;
  logic [7:0]  dhi_q;
  logic [7:0]  dlo_q;
  logic [7:0]  err_q;
  logic        ser_en_q;
  logic        ser_addr_q;
  logic        cmd_valid_q;
  logic [7:0]  cmd_addr_q;
  logic [15:0] cmd_data_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StPoll;
      idx_q       <= 3'd0;
      tmo_q       <= 16'd0;
      addr_q      <= 8'd0;
      dhi_q       <= 8'd0;
      dlo_q       <= 8'd0;
      err_q       <= 8'd0;
      ser_en_q    <= 1'b1;
      ser_addr_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= 8'd0;
      cmd_data_q  <= 16'd0;
    end else begin
      unique case (state_q)
        StPoll: begin
          // Idle time only counts once a frame has started.
          if (idx_q != 3'd0) begin
            if (tmo_q == TIMEOUT - 16'd1) begin
              idx_q <= 3'd0;
              tmo_q <= 16'd0;
              err_q <= sat_inc(err_q);
            end else begin
              tmo_q <= tmo_q + 16'd1;
            end
          end
          if (ser_rdata[0]) begin
            state_q    <= StRead;
            ser_addr_q <= 1'b1;
          end
        end

        StRead: begin
          tmo_q      <= 16'd0;
          ser_addr_q <= 1'b0;
          state_q    <= StPoll;
          case (idx_q)
            3'd0: begin
              if (ser_rdata == SYNC) begin
                idx_q <= 3'd1;
              end
            end
            3'd1: begin
              addr_q <= ser_rdata;
              idx_q  <= 3'd2;
            end
            3'd2: begin
              dhi_q <= ser_rdata;
              idx_q <= 3'd3;
            end
            3'd3: begin
              dlo_q <= ser_rdata;
              idx_q <= 3'd4;
            end
            3'd4: begin
              if (ser_rdata == (addr_q ^ dhi_q ^ dlo_q)) begin
                cmd_addr_q  <= addr_q;
                cmd_data_q  <= {dhi_q, dlo_q};
                cmd_valid_q <= 1'b1;
                ser_en_q    <= 1'b0;
                state_q     <= StIssue;
              end else begin
                err_q <= sat_inc(err_q);
                idx_q <= 3'd0;
              end
            end
            default: idx_q <= 3'd0;
          endcase
        end

        StIssue: begin
          // Receiver is left untouched here so pending bytes wait in its buffer.
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            ser_en_q    <= 1'b1;
            idx_q       <= 3'd0;
            state_q     <= StPoll;
          end
        end

        default: begin
          state_q    <= StPoll;
          ser_en_q   <= 1'b1;
          ser_addr_q <= 1'b0;
        end
      endcase
    end
  end

  assign ser_en    = ser_en_q;
  assign ser_wr    = 1'b0;
  assign ser_addr  = ser_addr_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_data  = cmd_data_q;
  assign err_cnt   = err_q;
  assign busy      = (idx_q != 3'd0) || (state_q == StIssue);

endmodule

// File: tb/tb_ser_loader.sv
// Randomized bench for ser_loader: the bench owns the serial receiver and a frame-level model,
// and compares every DUT output on every cycle, plus literal checks for the directed scenarios.
module tb_ser_loader;

  localparam logic [7:0]  SYNC = 8'hA5;
  localparam logic [15:0] TO   = 16'd100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ser_en, ser_wr, ser_addr;
  logic [7:0]  ser_rdata = 8'h00;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        busy;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  ser_loader #(.SYNC(SYNC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ser_en(ser_en), .ser_wr(ser_wr), .ser_addr(ser_addr),
    .ser_rdata(ser_rdata), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .busy(busy), .err_cnt(err_cnt)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Receiver byte buffer and stimulus knobs
  logic [7:0] rxq[$];
  int  rdy_pct = 100;
  int  cr_pct  = 100;
  bit  rst_req = 1'b0;

  // Frame-level model
  logic [7:0]  m_frame[$];
  bit          m_reading = 1'b0;
  bit          m_issuing = 1'b0;
  int          m_idle = 0;
  int          m_errs = 0;
  logic [7:0]  m_addr = 8'h00;
  logic [15:0] m_data = 16'h0000;

  // Observed command pulses
  int          pulses = 0;
  bit          prev_valid = 1'b0;
  logic [7:0]  seen_addr = 8'h00;
  logic [15:0] seen_data = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic compare();
    logic m_busy;
    m_busy = (m_frame.size() != 0) || m_issuing;
    chk("ctrl{en,wr,addr,valid,busy}", {27'b0, ser_en, ser_wr, ser_addr, cmd_valid, busy},
        {27'b0, !m_issuing, 1'b0, m_reading, m_issuing, m_busy});
    chk("err_cnt", {24'b0, err_cnt}, (m_errs > 255) ? 32'd255 : 32'(m_errs));
    chk("cmd_addr", {24'b0, cmd_addr}, {24'b0, m_addr});
    chk("cmd_data", {16'b0, cmd_data}, {16'b0, m_data});
    if (cmd_valid === 1'b1 && !prev_valid) begin
      pulses++;
      seen_addr = cmd_addr;
      seen_data = cmd_data;
    end
    prev_valid = (cmd_valid === 1'b1);
  endtask

  task automatic model_step(input bit rdy_bit);
    logic [7:0] b;
    if (rst_req) begin
      m_frame.delete();
      m_reading = 0; m_issuing = 0; m_idle = 0; m_errs = 0;
      m_addr = 8'h00; m_data = 16'h0000;
    end else if (m_issuing) begin
      if (cmd_ready) begin
        m_issuing = 0;
        m_frame.delete();
      end
    end else if (m_reading) begin
      b = rxq.pop_front();
      m_reading = 0;
      m_idle = 0;
      if (m_frame.size() == 0) begin
        if (b == SYNC) m_frame.push_back(b);
      end else if (m_frame.size() < 4) begin
        m_frame.push_back(b);
      end else if (b == (m_frame[1] ^ m_frame[2] ^ m_frame[3])) begin
        m_addr = m_frame[1];
        m_data = {m_frame[2], m_frame[3]};
        m_issuing = 1;
      end else begin
        m_errs++;
        m_frame.delete();
      end
    end else begin
      if (m_frame.size() != 0) begin
        m_idle++;
        if (m_idle == int'(TO)) begin
          m_frame.delete();
          m_idle = 0;
          m_errs++;
        end
      end
      if (rdy_bit) m_reading = 1;
    end
  endtask

  // One clock: check this cycle's outputs, drive inputs for the next edge, advance the model.
  task automatic cycle();
    bit rdy_bit;
    @(negedge clk);
    compare();
    reset = rst_req;
    cmd_ready = (int'($urandom_range(0, 99)) < cr_pct);
    if (m_issuing) rdy_bit = 1'($urandom);
    else rdy_bit = (rxq.size() != 0) && (int'($urandom_range(0, 99)) < rdy_pct);
    if (m_reading) ser_rdata = rxq[0];
    else ser_rdata = {7'($urandom), rdy_bit};
    model_step(rdy_bit);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    cycle();
  endtask

  task automatic drain(input int budget, input string name);
    int k = 0;
    while ((rxq.size() != 0 || m_reading || m_issuing) && k < budget) begin
      cycle();
      k++;
    end
    chk(name, 32'(k < budget), 32'd1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k = 0;
    while (cmd_valid !== 1'b1 && k < budget) begin
      cycle();
      k++;
    end
    chk(name, {31'b0, cmd_valid}, 32'd1);
  endtask

  task automatic push_bytes(input logic [7:0] bs[]);
    foreach (bs[i]) rxq.push_back(bs[i]);
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [15:0] d, input bit good);
    logic [7:0] c;
    c = a ^ d[15:8] ^ d[7:0];
    if (!good) c = c ^ 8'(1 << $urandom_range(0, 7));
    push_bytes('{SYNC, a, d[15:8], d[7:0], c});
  endtask

  initial begin
    int en_bad;
    int chg;
    logic [7:0]  h_addr;
    logic [15:0] h_data;

    // Reset state
    cycle();
    chk("rst_ser_en", {31'b0, ser_en}, 32'd1);
    chk("rst_ser_addr", {31'b0, ser_addr}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);

    // Basic good frame
    pulses = 0; rdy_pct = 100; cr_pct = 100;
    push_bytes('{8'hA5, 8'h12, 8'h34, 8'h56, 8'h70});
    drain(100, "g1_drain");
    run(3);
    chk("g1_pulses", pulses, 1);
    chk("g1_addr", {24'b0, seen_addr}, 32'h12);
    chk("g1_data", {16'b0, seen_data}, 32'h3456);
    chk("g1_err", {24'b0, err_cnt}, 32'd0);

    // Bad checksum, then a good frame
    do_reset(); pulses = 0;
    push_bytes('{8'hA5, 8'h12, 8'h34, 8'h56, 8'h71, 8'hA5, 8'hAB, 8'hCD, 8'hEF, 8'h89});
    drain(200, "bad_drain");
    run(3);
    chk("bad_err", {24'b0, err_cnt}, 32'd1);
    chk("bad_pulses", pulses, 1);
    chk("bad_next_addr", {24'b0, seen_addr}, 32'hAB);
    chk("bad_next_data", {16'b0, seen_data}, 32'hCDEF);

    // Junk before SYNC
    do_reset(); pulses = 0;
    push_bytes('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h02, 8'h03});
    drain(200, "junk_drain");
    run(3);
    chk("junk_addr", {24'b0, seen_addr}, 32'h01);
    chk("junk_data", {16'b0, seen_data}, 32'h0002);
    chk("junk_err", {24'b0, err_cnt}, 32'd0);

    // Backpressure with a second frame waiting
    do_reset(); pulses = 0; cr_pct = 0;
    push_bytes('{8'hA5, 8'h12, 8'h34, 8'h56, 8'h70, 8'hA5, 8'hAB, 8'hCD, 8'hEF, 8'h89});
    wait_valid(100, "bp_valid");
    h_addr = cmd_addr; h_data = cmd_data; en_bad = 0; chg = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (ser_en !== 1'b0) en_bad++;
      if (cmd_valid !== 1'b1 || cmd_addr !== h_addr || cmd_data !== h_data) chg++;
    end
    chk("bp_ser_en_low", en_bad, 0);
    chk("bp_stable", chg, 0);
    chk("bp_held_addr", {24'b0, h_addr}, 32'h12);
    cr_pct = 100;
    drain(200, "bp_drain");
    run(3);
    chk("bp_pulses", pulses, 2);
    chk("bp_second_addr", {24'b0, seen_addr}, 32'hAB);

    // Inter-byte timeout, then error counter saturation
    do_reset();
    push_bytes('{8'hA5, 8'h12});
    drain(50, "to_drain");
    run(98);
    chk("to_busy_before", {31'b0, busy}, 32'd1);
    run(3);
    chk("to_busy_after", {31'b0, busy}, 32'd0);
    chk("to_err", {24'b0, err_cnt}, 32'd1);
    for (int i = 0; i < 256; i++) push_frame(8'(i), 16'(i * 3), 1'b0);
    drain(4000, "sat_drain");
    chk("sat_err", {24'b0, err_cnt}, 32'hFF);
    for (int i = 0; i < 4; i++) push_frame(8'(i), 16'h1234, 1'b0);
    drain(200, "sat_hold_drain");
    chk("sat_hold", {24'b0, err_cnt}, 32'hFF);

    // Reset mid-frame and during ISSUE
    do_reset(); pulses = 0;
    push_bytes('{8'hA5, 8'h12});
    drain(50, "rm_drain");
    do_reset();
    chk("rm_ser_en", {31'b0, ser_en}, 32'd1);
    chk("rm_ser_addr", {31'b0, ser_addr}, 32'd0);
    chk("rm_ser_wr", {31'b0, ser_wr}, 32'd0);
    chk("rm_busy", {31'b0, busy}, 32'd0);
    push_bytes('{8'hA5, 8'h01, 8'h00, 8'h02, 8'h03});
    drain(100, "rm_next_drain");
    run(3);
    chk("rm_next_addr", {24'b0, seen_addr}, 32'h01);
    chk("rm_next_data", {16'b0, seen_data}, 32'h0002);
    cr_pct = 0;
    push_bytes('{8'hA5, 8'hAB, 8'hCD, 8'hEF, 8'h89});
    wait_valid(100, "ri_valid");
    do_reset();
    chk("ri_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    chk("ri_cmd_addr", {24'b0, cmd_addr}, 32'd0);
    chk("ri_cmd_data", {16'b0, cmd_data}, 32'd0);
    chk("ri_busy", {31'b0, busy}, 32'd0);
    chk("ri_err", {24'b0, err_cnt}, 32'd0);
    cr_pct = 100;
    push_bytes('{8'hA5, 8'h12, 8'h34, 8'h56, 8'h70});
    drain(100, "ri_next_drain");
    run(3);
    chk("ri_next_addr", {24'b0, seen_addr}, 32'h12);
    chk("ri_next_data", {16'b0, seen_data}, 32'h3456);

    // Randomized traffic: good, bad, junk and truncated frames with random gaps
    for (int it = 0; it < 60; it++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      rdy_pct = int'($urandom_range(30, 100));
      cr_pct = int'($urandom_range(20, 100));
      case (kind)
        0: push_frame(8'($urandom), 16'($urandom), 1'b1);
        1: push_frame(8'($urandom), 16'($urandom), 1'b0);
        2: for (int j = 0; j < int'($urandom_range(1, 4)); j++) rxq.push_back(8'($urandom));
        default: begin
          rxq.push_back(SYNC);
          for (int j = 0; j < int'($urandom_range(0, 3)); j++) rxq.push_back(8'($urandom));
        end
      endcase
      if (it % 13 == 7) do_reset();
      run(int'($urandom_range(0, 140)));
    end
    cr_pct = 100; rdy_pct = 100;
    drain(5000, "rand_drain");
    run(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ser_loader.md
SER_LOADER -- requirements
Module: ser_loader

Interface
REQ-001 SHALL have parameter SYNC, default 8'hA5, frame start byte.
REQ-002 SHALL have parameter TIMEOUT, default 16'd50000, maximum idle cycles between bytes inside a frame.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous and active-high reset.
REQ-005 SHALL have port ser_en, output, 1, bus enable to the serial receiver register port.
REQ-006 SHALL have port ser_wr, output, 1, bus write strobe to the serial receiver; constant 0.
REQ-007 SHALL have port ser_addr, output, 1, register select: 0 = rcv ctrl (bit0 = ready), 1 = rcv data (a read consumes the byte).
REQ-008 SHALL have port ser_rdata, input, 8, combinational read data from the serial receiver.
REQ-009 SHALL have port cmd_valid, output, 1, decoded command available.
REQ-010 SHALL have port cmd_ready, input, 1, consumer accepts the command.
REQ-011 SHALL have port cmd_addr, output, 8, command register address.
REQ-012 SHALL have port cmd_data, output, 16, command write data.
REQ-013 SHALL have port busy, output, 1, high while a frame is partly received or a command is pending.
REQ-014 SHALL have port err_cnt, output, 8, saturating count of dropped frames.

Function
REQ-015 SHALL receive frames of 5 bytes: SYNC, ADDR, DHI, DLO, CHK, where CHK = ADDR ^ DHI ^ DLO.
REQ-016 SHALL implement states POLL, READ and ISSUE, plus a byte index idx in 0..4.
REQ-017 In POLL: ser_en=1, ser_addr=0. If ser_rdata[0]=1, go to READ next cycle; otherwise stay in POLL.
REQ-018 In READ: ser_en=1, ser_addr=1 for exactly one cycle. Capture ser_rdata at that edge, then go to POLL, except as stated in REQ-021.
REQ-019 When idx=0, capture of SYNC SHALL set idx=1. Any other byte SHALL be discarded silently, leaving idx=0 and err_cnt unchanged.
REQ-020 When idx is 1, 2 or 3, the captured byte SHALL be stored as ADDR, DHI or DLO respectively, and idx SHALL increment.
REQ-021 When idx=4, the captured byte is CHK:
  - match: load cmd_addr=ADDR, cmd_data={DHI,DLO}, then go to ISSUE.
  - mismatch: err_cnt+1, idx=0, go to POLL.
REQ-022 In ISSUE: ser_en=0, cmd_valid=1, and cmd_addr/cmd_data held stable. On cmd_ready=1, the next cycle SHALL have cmd_valid=0, idx=0 and state POLL.
REQ-023 Latency SHALL be: cmd_valid rises in the cycle after the READ cycle that captured a valid CHK.
REQ-024 ser_rdata SHALL be sampled only in the POLL and READ cycles; no ser read SHALL be issued during ISSUE (backpressure holds bytes in the receiver).
REQ-025 Inter-byte timeout: a 16-bit counter clears on every READ cycle and increments each POLL cycle while idx!=0.
REQ-026 When the timeout counter reaches TIMEOUT, the block SHALL set idx=0, clear the counter and add 1 to err_cnt. The counter SHALL NOT advance while idx=0.
REQ-027 err_cnt SHALL saturate at 8'hFF. A drop and saturation in the same cycle SHALL hold 8'hFF.
REQ-028 A SYNC byte received when idx is 1..4 SHALL be treated as data; there is no mid-frame resync.
REQ-029 busy SHALL equal (idx!=0) OR (state==ISSUE).

Reset
REQ-030 reset=1 SHALL force state=POLL, idx=0, timeout counter=0, err_cnt=0, cmd_valid=0, cmd_addr=0 and cmd_data=0. Consequently ser_en=1, ser_addr=0, ser_wr=0 and busy=0 in the following cycle.
REQ-031 reset SHALL take priority over all other events, including mid-frame and during ISSUE; any partial frame or pending command SHALL be discarded without counting an error.

Verification
REQ-032 Bytes A5,12,34,56,70 with cmd_ready=1 -> one cmd_valid pulse with cmd_addr=12, cmd_data=3456; err_cnt=0.
REQ-033 Bytes A5,12,34,56,71 -> no cmd_valid; err_cnt=1; a following good frame is issued normally.
REQ-034 Bytes 00,FF,A5,01,00,02,03 -> junk discarded; cmd_addr=01, cmd_data=0002; err_cnt=0.
REQ-035 cmd_ready=0 for 20 cycles with the next frame already waiting -> cmd_valid and outputs stable; ser_en=0 throughout; the second frame is read after the handshake.
REQ-036 TIMEOUT=100; send A5,12 then idle 100 cycles -> idx=0, err_cnt=1, busy=0; 256 bad frames -> err_cnt=FF.
REQ-037 reset asserted after A5,12 and during ISSUE -> outputs per REQ-030; a subsequent frame decodes correctly.
